// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and default width for the period meter
package period_meter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2, HOLD = 2'd3} state_t;
   localparam int DEFAULT_WIDTH = 24;
endpackage

// File: rtl/period_meter_sync_edge.sv
// sync_edge: multi-flop synchroniser with single-cycle rising-edge pulse
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic [STAGES-1:0] sync;
   logic              prev;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   assign rise = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/period_meter.sv
// period_meter: counts cei ticks between two rising edges of sig_in, result on valid/ack
module period_meter
   import period_meter_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cei,
   input  logic             sig_in,
   input  logic             start,
   output logic [WIDTH-1:0] period,
   output logic             overflow,
   output logic             valid,
   input  logic             ack,
   output logic             busy
);
   state_t           state;
   logic [WIDTH-1:0] count;
   logic             sat_flag;
   logic             rise;
   logic             full;
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sig_in),
      .rise  (rise)
   );
   assign full = count == '1;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         count    <= '0;
         sat_flag <= 1'b0;
         period   <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) state <= ARM;
            ARM: if (rise) begin
               state    <= MEASURE;
               count    <= '0;
               sat_flag <= 1'b0;
            end
            MEASURE: if (rise) begin
               period   <= (cei && !full) ? count + 1'b1 : count;
               overflow <= sat_flag | (cei & full);
               valid    <= 1'b1;
               state    <= HOLD;
            end else if (cei) begin
               if (full) sat_flag <= 1'b1;
               else count <= count + 1'b1;
            end
            HOLD: if (ack) begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the interval between two consecutive rising edges of an asynchronous input.
- The interval is counted in clock-enable ticks: cei pulses, e.g. the zero output of a 10 Hz programmable timer.
- This is the inverse of the tick generator: that block turns a count into a period; this block turns a period back into a count.
- Result is presented on a valid/ack handshake to the consuming logic.

Parameters:
- WIDTH, 24, width of period counter and result.
- SYNC_STAGES, 2, flops in the sig_in synchroniser (minimum 2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cei  in  1  count-enable tick, one clk cycle wide when high.
- sig_in  in  1  asynchronous input whose period is measured.
- start  in  1  single-cycle request to arm one measurement.
- period  out  WIDTH  captured tick count, stable while valid=1.
- overflow  out  1  counter saturated during the captured measurement.
- valid  out  1  result available.
- ack  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; count, period, overflow and valid = 0.
  - Synchroniser flops and edge-history flop = 0.
- Synchroniser and edge detect:
  - sig_in passes through SYNC_STAGES flops.
  - rise = sync_out & ~prev. It is high for one cycle, SYNC_STAGES cycles after sig_in is first sampled high.
- FSM:
  - IDLE: start=1 -> ARM. rise is ignored, even when it coincides with start; a fresh edge is required.
  - ARM: rise=1 -> MEASURE and count<=0. A cei in that same cycle is not counted.
  - MEASURE, rise=0:
    - If cei=1 and count != all-ones: count<=count+1.
    - If cei=1 and count == all-ones: count holds and sat_flag<=1.
  - MEASURE, rise=1:
    - period<=count, plus 1 if cei=1 in the same cycle (saturating; saturation sets overflow).
    - overflow<=sat_flag or saturation in this cycle; valid<=1; go to HOLD.
  - HOLD: valid=1 and period/overflow are frozen. Further rise events are ignored. ack=1 -> valid<=0, state IDLE on the next cycle.
- start outside IDLE is ignored; there is no abort.
- ack outside HOLD is ignored.
- All outputs are registered except busy, which is decoded from state.
- sat_flag is cleared on entry to MEASURE.
- Latency: valid rises 1 cycle after the rise cycle that ends the measurement.
- Edge cases:
  - Back-to-back start pulses: the second is ignored.
  - reset during MEASURE or HOLD: immediate return to the reset values, with no partial result.
  - Result definition: period equals the number of cei-high cycles strictly after the arming rise cycle, up to and including the terminating rise cycle.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, ARM=2'd1, MEASURE=2'd2, HOLD=2'd3;
  - default WIDTH constant (24).
- One sub-module: sync_edge.
  - Contains the SYNC_STAGES synchroniser plus rising-edge detector.
  - Ports: clk, reset, d, rise.
  - Reusable for button and switch inputs.

Test Plan:
- cei tied to 1; start, then sig_in rising edges 10 cycles apart -> period=10, overflow=0, valid high 1 cycle after the second rise cycle.
- cei high 1 cycle in 4; sig_in edges 40 cycles apart -> period=10. Repeat with the terminating rise coincident with a cei pulse -> that pulse is included in the count.
- WIDTH=4, cei=1, edges 20 cycles apart -> period=15, overflow=1. A following 8-cycle measurement -> period=8, overflow=0.
- Hold ack=0 for 50 cycles while sig_in keeps toggling -> period and valid stay constant, busy=1. Then ack=1 -> valid=0 and busy=0 next cycle; start during HOLD has no effect.
- reset pulled low mid-MEASURE at count=5 -> valid=0, busy=0, period=0 immediately. After release, start re-arms normally.
- sig_in already high at start and no new edge arrives -> FSM remains in ARM, valid=0.
